hwpf_stride_snooper_array: RTL and testbench
============================================

HWPF_STRIDE_SNOOPER_ARRAY -- requirements
Module: hwpf_stride_snooper_array

Interface
REQ-001 Parameter NUM_SNOOPERS, default 4: number of independent snooper entries, range 1..16.
REQ-002 Parameter NLINE_WIDTH, default 40: width of cache-line addresses.
REQ-003 Parameter HIT_THRESHOLD, default 3: hits an entry needs before it fires a trigger, range 1..2^CNT_WIDTH-1.
REQ-004 Parameter CNT_WIDTH, default 4: width of the per-entry hit counter.
REQ-005 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst_ni, input, 1: reset, synchronous and active-low.
REQ-007 Port cfg_valid_i, input, 1: programming strobe for one entry.
REQ-008 Port cfg_idx_i, input, $clog2(NUM_SNOOPERS) (min 1): index of the entry to program.
REQ-009 Port cfg_en_i, input, 1: enable value to write.
REQ-010 Port cfg_base_i, input, NLINE_WIDTH: base line to write.
REQ-011 Port snoop_valid_i, input, 1: snoop address is valid this cycle.
REQ-012 Port snoop_nline_i, input, NLINE_WIDTH: line address to snoop.
REQ-013 Port match_valid_o, output, 1: registered match result is valid.
REQ-014 Port match_vec_o, output, NUM_SNOOPERS: entries that matched, one bit per entry.
REQ-015 Port match_idx_o, output, $clog2(NUM_SNOOPERS): lowest-index matching entry.
REQ-016 Port trigger_o, output, NUM_SNOOPERS: one-cycle pulse per entry when that entry reaches its threshold.
REQ-017 Port base_o, output, NUM_SNOOPERS*NLINE_WIDTH: current base line of each entry, packed with entry 0 in the LSBs.

Function
REQ-018 Each entry holds en, base (NLINE_WIDTH bits) and cnt (CNT_WIDTH bits) as registers.
REQ-019 Entry i hits in a cycle when snoop_valid_i=1, en[i]=1 and base[i]==snoop_nline_i.
REQ-020 Latency: match_valid_o, match_vec_o and match_idx_o are registered and appear exactly 1 cycle after the snoop.
- match_valid_o=1 iff at least one entry hit.
- When no entry hit: match_vec_o=0 and match_idx_o=0.
REQ-021 On a hit, cnt[i] increments; it never exceeds HIT_THRESHOLD.
REQ-022 When a hit makes cnt[i] reach HIT_THRESHOLD:
- trigger_o[i] pulses high for 1 cycle, registered, aligned with match_valid_o;
- cnt[i] clears to 0;
- base[i] becomes base[i]+1 modulo 2^NLINE_WIDTH, so the all-ones value wraps to 0.
REQ-023 Multiple entries may hit and trigger in the same cycle; each entry is updated independently.
REQ-024 cfg_valid_i=1 writes en, base and cnt=0 to entry cfg_idx_i at the clock edge.
REQ-025 If cfg_idx_i >= NUM_SNOOPERS, the write is ignored.
REQ-026 If a cfg write and a hit hit the same entry in the same cycle:
- the match and trigger outputs use the pre-write state;
- the cfg write wins for en, base and cnt, and the hit's counter and base update is discarded.
REQ-027 A disabled entry never hits and holds its cnt and base; cnt does not decay.
REQ-028 base_o reflects the entry registers with no added delay.
REQ-029 No backpressure: one snoop per cycle is accepted unconditionally.

Reset
REQ-030 While rst_ni=0 at a rising edge, all en, base and cnt registers clear to 0.
REQ-031 While rst_ni=0 at a rising edge, match_valid_o, match_vec_o, match_idx_o and trigger_o clear to 0.
REQ-032 Reset overrides a simultaneous cfg write or snoop; a snoop in the reset cycle produces no output afterwards.
REQ-033 Reset asserted mid-sequence discards all partial hit counts.

Verification
REQ-034 Program entry 1 with en=1, base=0x100, then snoop 0x100 three times (HIT_THRESHOLD=3):
- responses 1, 2 and 3: match_valid_o=1, match_vec_o=0010, match_idx_o=1;
- third response only: trigger_o=0010;
- afterwards base_o[1]=0x101.
REQ-035 Program entries 0 and 2 both with base 0x40, then snoop 0x40:
- match_vec_o=0101, match_idx_o=0, one cycle later.
REQ-036 Set entry 3 base to all-ones and snoop it 3 times:
- trigger_o[3] pulses;
- base_o[3] becomes 0.
REQ-037 Entry 0 has cnt=2 and base=0x80; in the same cycle issue cfg(idx 0, base 0x200) and snoop 0x80:
- trigger_o[0]=1 next cycle;
- base_o[0]=0x200 and cnt=0 afterwards.
REQ-038 Snoop with an entry disabled, or with a mismatching address:
- match_valid_o=0, match_vec_o=0, trigger_o=0.
REQ-039 Pulse rst_ni low after 2 hits on an entry, then reprogram it:
- all outputs are 0 during reset;
- 3 further hits are needed for a trigger.

Source files
------------

// File: rtl/hwpf_stride_snooper_array.sv
// Array of line-address snoopers. Each entry counts hits on its base line; on reaching
// the threshold it pulses a trigger, clears its count and advances its base by one line.

module hwpf_snooper_entry #(
    parameter int NLINE_WIDTH   = 40,
    parameter int CNT_WIDTH     = 4,
    parameter int HIT_THRESHOLD = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   snoop_valid,
    input  logic [NLINE_WIDTH-1:0] snoop_nline,
    input  logic                   cfg_wr,
    input  logic                   cfg_en,
    input  logic [NLINE_WIDTH-1:0] cfg_base,
    output logic                   hit,
    output logic                   fire,
    output logic [NLINE_WIDTH-1:0] base
);
    localparam logic [CNT_WIDTH:0] THR = (CNT_WIDTH+1)'(HIT_THRESHOLD);

    logic                 en;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH:0]   cnt_inc;

    // One spare bit so the increment can never alias back below the threshold.
    assign cnt_inc = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
    assign hit     = snoop_valid && en && (base == snoop_nline);
    assign fire    = hit && (cnt_inc == THR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en   <= 1'b0;
            base <= '0;
            cnt  <= '0;
        end else if (cfg_wr) begin
            // Programming wins over a same-cycle hit on this entry.
            en   <= cfg_en;
            base <= cfg_base;
            cnt  <= '0;
        end else if (fire) begin
            cnt  <= '0;
            base <= base + NLINE_WIDTH'(1);
        end else if (hit) begin
            cnt  <= cnt_inc[CNT_WIDTH-1:0];
        end
    end
endmodule

module hwpf_stride_snooper_array #(
    parameter int NUM_SNOOPERS  = 4,
    parameter int NLINE_WIDTH   = 40,
    parameter int HIT_THRESHOLD = 3,
    parameter int CNT_WIDTH     = 4,
    localparam int IDX_W        = (NUM_SNOOPERS > 1) ? $clog2(NUM_SNOOPERS) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                cfg_valid_i,
    input  logic [IDX_W-1:0]                    cfg_idx_i,
    input  logic                                cfg_en_i,
    input  logic [NLINE_WIDTH-1:0]              cfg_base_i,
    input  logic                                snoop_valid_i,
    input  logic [NLINE_WIDTH-1:0]              snoop_nline_i,
    output logic                                match_valid_o,
    output logic [NUM_SNOOPERS-1:0]             match_vec_o,
    output logic [IDX_W-1:0]                    match_idx_o,
    output logic [NUM_SNOOPERS-1:0]             trigger_o,
    output logic [NUM_SNOOPERS*NLINE_WIDTH-1:0] base_o
);
    logic [NUM_SNOOPERS-1:0]                  hit;
    logic [NUM_SNOOPERS-1:0]                  fire;
    logic [NUM_SNOOPERS-1:0]                  cfg_wr;
    logic [NUM_SNOOPERS-1:0][NLINE_WIDTH-1:0] base;
    logic [IDX_W-1:0]                         first_idx;

    genvar g;
    generate
        for (g = 0; g < NUM_SNOOPERS; g++) begin : g_entry
            // Out-of-range indices decode to no entry and are dropped.
            assign cfg_wr[g] = cfg_valid_i && (cfg_idx_i == IDX_W'(g));

            hwpf_snooper_entry #(
                .NLINE_WIDTH  (NLINE_WIDTH),
                .CNT_WIDTH    (CNT_WIDTH),
                .HIT_THRESHOLD(HIT_THRESHOLD)
            ) u_entry (
                .clk        (clk_i),
                .rst_n      (rst_ni),
                .snoop_valid(snoop_valid_i),
                .snoop_nline(snoop_nline_i),
                .cfg_wr     (cfg_wr[g]),
                .cfg_en     (cfg_en_i),
                .cfg_base   (cfg_base_i),
                .hit        (hit[g]),
                .fire       (fire[g]),
                .base       (base[g])
            );
        end
    endgenerate

    assign base_o = base;

    always_comb begin
        first_idx = '0;
        for (int i = NUM_SNOOPERS - 1; i >= 0; i--) begin
            if (hit[i]) first_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            match_valid_o <= 1'b0;
            match_vec_o   <= '0;
            match_idx_o   <= '0;
            trigger_o     <= '0;
        end else begin
            match_valid_o <= |hit;
            match_vec_o   <= hit;
            match_idx_o   <= first_idx;
            trigger_o     <= fire;
        end
    end
endmodule

// File: tb/tb_hwpf_stride_snooper_array.sv
// Bench for hwpf_stride_snooper_array: directed scenarios then random traffic,
// all compared against a per-entry behavioural model.

module tb_hwpf_stride_snooper_array;
    localparam int N   = 4;
    localparam int W   = 40;
    localparam int THR = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_valid;
    logic [1:0]     cfg_idx;
    logic           cfg_en;
    logic [W-1:0]   cfg_base;
    logic           snoop_valid;
    logic [W-1:0]   snoop_nline;
    logic           match_valid;
    logic [N-1:0]   match_vec;
    logic [1:0]     match_idx;
    logic [N-1:0]   trigger;
    logic [N*W-1:0] base_bus;

    hwpf_stride_snooper_array #(
        .NUM_SNOOPERS(N), .NLINE_WIDTH(W), .HIT_THRESHOLD(THR), .CNT_WIDTH(4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_valid_i  (cfg_valid),
        .cfg_idx_i    (cfg_idx),
        .cfg_en_i     (cfg_en),
        .cfg_base_i   (cfg_base),
        .snoop_valid_i(snoop_valid),
        .snoop_nline_i(snoop_nline),
        .match_valid_o(match_valid),
        .match_vec_o  (match_vec),
        .match_idx_o  (match_idx),
        .trigger_o    (trigger),
        .base_o       (base_bus)
    );

    always #5 clk = ~clk;

    // Reference state: one record per entry, plus expected registered outputs.
    logic         m_en   [N];
    logic [W-1:0] m_base [N];
    int           m_cnt  [N];
    logic         e_valid;
    logic [N-1:0] e_vec;
    int           e_idx;
    logic [N-1:0] e_trig;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] dut_base(input int i);
        logic [N*W-1:0] b;
        b = base_bus;
        return b[i*W +: W];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 1'b0; m_base[i] = '0; m_cnt[i] = 0;
        end
        e_valid = 1'b0; e_vec = '0; e_idx = 0; e_trig = '0;
    endtask

    // Apply one cycle of stimulus, advance the model, then compare everything.
    task automatic step(input logic rst, input logic cv, input logic [1:0] ci, input logic ce,
                        input logic [W-1:0] cb, input logic sv, input logic [W-1:0] sn);
        rst_n = rst; cfg_valid = cv; cfg_idx = ci; cfg_en = ce; cfg_base = cb;
        snoop_valid = sv; snoop_nline = sn;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            e_vec = '0; e_trig = '0; e_idx = 0;
            for (int i = 0; i < N; i++)
                if (sv && m_en[i] && m_base[i] == sn) e_vec[i] = 1'b1;
            e_valid = (e_vec != 0);
            for (int i = N - 1; i >= 0; i--) if (e_vec[i]) e_idx = i;
            for (int i = 0; i < N; i++) begin
                if (e_vec[i]) begin
                    m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == THR) begin
                        e_trig[i] = 1'b1;
                        m_cnt[i]  = 0;
                        m_base[i] = m_base[i] + 1;
                    end
                end
            end
            if (cv && ci < N) begin
                m_en[ci] = ce; m_base[ci] = cb; m_cnt[ci] = 0;
            end
        end
        #1;
        chk("valid", 64'(match_valid), 64'(e_valid));
        chk("vec",   64'(match_vec),   64'(e_vec));
        chk("idx",   64'(match_idx),   64'(e_idx));
        chk("trig",  64'(trigger),     64'(e_trig));
        for (int i = 0; i < N; i++) chk($sformatf("base%0d", i), 64'(dut_base(i)), 64'(m_base[i]));
    endtask

    task automatic cfg(input logic [1:0] i, input logic en, input logic [W-1:0] b);
        step(1'b1, 1'b1, i, en, b, 1'b0, '0);
    endtask

    task automatic snoop(input logic [W-1:0] a);
        step(1'b1, 1'b0, 2'd0, 1'b0, '0, 1'b1, a);
    endtask

    logic [W-1:0] ones;

    initial begin
        ones = '1;
        model_reset();
        // Reset with traffic present: nothing may leak out.
        step(1'b0, 1'b1, 2'd1, 1'b1, 40'h100, 1'b1, 40'h0);
        step(1'b0, 1'b0, 2'd0, 1'b0, '0, 1'b1, 40'h0);

        // Single entry reaches threshold and advances its base.
        cfg(2'd1, 1'b1, 40'h100);
        for (int k = 0; k < 3; k++) begin
            snoop(40'h100);
            chk("r34_vec", 64'(match_vec), 64'h2);
            chk("r34_trig", 64'(trigger), (k == 2) ? 64'h2 : 64'h0);
        end
        chk("r34_base", 64'(dut_base(1)), 64'h101);

        // Two entries on the same line: lowest index reported.
        cfg(2'd0, 1'b1, 40'h40);
        cfg(2'd2, 1'b1, 40'h40);
        snoop(40'h40);
        chk("r35_vec", 64'(match_vec), 64'h5);
        chk("r35_idx", 64'(match_idx), 64'h0);

        // All-ones base wraps to zero on trigger.
        cfg(2'd3, 1'b1, ones);
        for (int k = 0; k < 3; k++) snoop(ones);
        chk("r36_trig", 64'(trigger), 64'h8);
        chk("r36_base", 64'(dut_base(3)), 64'h0);

        // Cfg and triggering hit on the same entry in the same cycle.
        cfg(2'd0, 1'b1, 40'h80);
        snoop(40'h80); snoop(40'h80);
        step(1'b1, 1'b1, 2'd0, 1'b1, 40'h200, 1'b1, 40'h80);
        chk("r37_trig", 64'(trigger), 64'h1);
        chk("r37_base", 64'(dut_base(0)), 64'h200);
        snoop(40'h200); snoop(40'h200);
        chk("r37_cnt_clear", 64'(trigger), 64'h0);
        snoop(40'h200);
        chk("r37_third", 64'(trigger), 64'h1);

        // Disabled entry and mismatching address.
        cfg(2'd2, 1'b0, 40'h55);
        snoop(40'h55);
        chk("r38_dis", 64'(match_valid), 64'h0);
        snoop(40'h12345);
        chk("r38_miss", 64'(match_vec), 64'h0);

        // Reset mid-sequence discards partial counts.
        cfg(2'd1, 1'b1, 40'h300);
        snoop(40'h300); snoop(40'h300);
        step(1'b0, 1'b0, 2'd0, 1'b0, '0, 1'b1, 40'h300);
        chk("r39_rst_trig", 64'(trigger), 64'h0);
        cfg(2'd1, 1'b1, 40'h300);
        snoop(40'h300); snoop(40'h300);
        chk("r39_no_early", 64'(trigger), 64'h0);
        snoop(40'h300);
        chk("r39_trig", 64'(trigger), 64'h2);

        // Random traffic, biased towards live bases so hits are common.
        for (int n = 0; n < 3000; n++) begin
            logic         r, cv, ce, sv;
            logic [1:0]   ci;
            logic [W-1:0] cb, sn;
            r  = ($urandom_range(0, 199) != 0);
            cv = ($urandom_range(0, 5) == 0);
            ci = 2'($urandom_range(0, 3));
            ce = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 3))
                0: cb = ones;
                1: cb = ones - 40'd1;
                default: cb = 40'(32'($urandom_range(0, 7)));
            endcase
            sv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) sn = m_base[$urandom_range(0, N - 1)];
            else sn = 40'(32'($urandom_range(0, 9)));
            step(r, cv, ci, ce, cb, sv, sn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
